// File: rtl/avr_pmem_pkg.sv
// Shared encodings for the AVR program-memory responder: loader FSM states,
// loader command bytes and the word shown to fetch while the loader is busy.
package avr_pmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_A_LO  = 3'd1,
        ST_A_HI  = 3'd2,
        ST_W_LO  = 3'd3,
        ST_W_HI  = 3'd4,
        ST_RB_LO = 3'd5,
        ST_RB_HI = 3'd6
    } pmem_state_e;

    localparam logic [7:0]  CMD_SETA = 8'hA0;
    localparam logic [7:0]  CMD_WR   = 8'hA1;
    localparam logic [7:0]  CMD_RD   = 8'hA2;
    localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/avr_pmem_array.sv
// DEPTH x 16 program word array: two combinational read ports (fetch and
// loader read-back) and one synchronous write port. Contents are never reset.
module avr_pmem_array #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [15:0]       rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [15:0]       rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [15:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/avr_pmem_ctrl.sv
// Program-memory responder: zero-latency fetch port plus a byte-wide loader
// that parses SETA/WR (and RD when PMEM_READBACK_EN is defined) commands.
//
// Loader handshake: a byte moves on a rising edge where ld_valid && ld_ready;
// read-back bytes move on a rising edge where rb_valid && rb_ready. Neither
// side may retract a valid byte, and a stalled valid keeps its data stable.
module avr_pmem_ctrl
    import avr_pmem_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] prog_addr,
    output logic [15:0] prog_data,
    output logic        busy,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        rb_valid,
    output logic [7:0]  rb_data,
    input  logic        rb_ready
);

    pmem_state_e       state;
    pmem_state_e       state_next;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        lo_latch;
    logic              ld_accept;
    logic              mem_we;
    logic [15:0]       addr_full;
    logic [15:0]       fetch_word;
    logic [15:0]       rb_word;
    logic              unused_sink;

    assign ld_accept = ld_valid && ld_ready;
    assign addr_full = {ld_data, lo_latch};

    avr_pmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (CLK),
        .we      (mem_we),
        .waddr   (ld_addr),
        .wdata   ({ld_data, lo_latch}),
        .raddr_a (prog_addr[ADDR_W-1:0]),
        .rdata_a (fetch_word),
        .raddr_b (ld_addr),
        .rdata_b (rb_word)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ld_accept) begin
                    if (ld_data == CMD_SETA) begin
                        state_next = ST_A_LO;
                    end else if (ld_data == CMD_WR) begin
                        state_next = ST_W_LO;
                    end
`ifdef PMEM_READBACK_EN
                    else if (ld_data == CMD_RD) begin
                        state_next = ST_RB_LO;
                    end
`endif
                end
            end
            ST_A_LO: if (ld_accept) state_next = ST_A_HI;
            ST_A_HI: if (ld_accept) state_next = ST_IDLE;
            ST_W_LO: if (ld_accept) state_next = ST_W_HI;
            ST_W_HI: if (ld_accept) state_next = ST_IDLE;
`ifdef PMEM_READBACK_EN
            ST_RB_LO: if (rb_ready) state_next = ST_RB_HI;
            ST_RB_HI: if (rb_ready) state_next = ST_IDLE;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        ld_ready = (state != ST_RB_LO) && (state != ST_RB_HI);
        mem_we   = ld_accept && (state == ST_W_HI);
`ifdef PMEM_READBACK_EN
        rb_valid = (state == ST_RB_LO) || (state == ST_RB_HI);
        rb_data  = 8'h00;
        if (state == ST_RB_LO) begin
            rb_data = rb_word[7:0];
        end else if (state == ST_RB_HI) begin
            rb_data = rb_word[15:8];
        end
`else
        rb_valid = 1'b0;
        rb_data  = 8'h00;
`endif
    end

    // The low byte latch is shared by address and data commands.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_addr  <= '0;
            lo_latch <= 8'h00;
        end else begin
            if (ld_accept && (state == ST_A_LO || state == ST_W_LO)) begin
                lo_latch <= ld_data;
            end
            if (ld_accept && state == ST_A_HI) begin
                ld_addr <= addr_full[ADDR_W-1:0];
            end
            if (mem_we) begin
                ld_addr <= ld_addr + ADDR_W'(1);
            end
`ifdef PMEM_READBACK_EN
            if (state == ST_RB_HI && rb_ready) begin
                ld_addr <= ld_addr + ADDR_W'(1);
            end
`endif
        end
    end

    // Write data reaches the array in the same edge, so it is visible next cycle.
    assign prog_data = busy ? NOP_WORD : fetch_word;

    assign unused_sink = &{1'b0, prog_addr[15:ADDR_W], addr_full[15:ADDR_W],
                           rb_word, rb_ready};

endmodule

// File: tb/tb_avr_pmem_ctrl.sv
// Self-checking bench for avr_pmem_ctrl: directed command sequences plus
// random traffic, compared cycle by cycle against a command-level model.
module tb_avr_pmem_ctrl;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] prog_addr = 16'h0000;
    logic [15:0] prog_data;
    logic        busy;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_ready;
    logic        rb_valid;
    logic [7:0]  rb_data;
    logic        rb_ready = 1'b0;

    avr_pmem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .busy      (busy),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .rb_valid  (rb_valid),
        .rb_data   (rb_data),
        .rb_ready  (rb_ready)
    );

    always #5 CLK = ~CLK;

    // Reference model: the command in progress plus the argument bytes
    // collected so far; memory cells are tracked with a "known" flag.
    int          m_cmd = -1;
    logic [7:0]  m_args[$];
    int          m_rb_idx = 0;
    int          m_addr = 0;
    logic [15:0] m_mem[DEPTH];
    bit          m_known[DEPTH];
    logic [15:0] pa = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_cmd_ok(input logic [7:0] b);
`ifdef PMEM_READBACK_EN
        return (b == 8'hA0) || (b == 8'hA1) || (b == 8'hA2);
`else
        return (b == 8'hA0) || (b == 8'hA1);
`endif
    endfunction

    task automatic model_reset();
        m_cmd = -1;
        m_args.delete();
        m_rb_idx = 0;
        m_addr = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [15:0] w;
        if (m_cmd < 0) begin
            if (model_cmd_ok(b)) m_cmd = int'(b);
        end else begin
            m_args.push_back(b);
            if (m_args.size() == 2) begin
                w = {m_args[1], m_args[0]};
                if (m_cmd == 'hA0) begin
                    m_addr = int'(w) % DEPTH;
                end else begin
                    m_mem[m_addr] = w;
                    m_known[m_addr] = 1'b1;
                    m_addr = (m_addr + 1) % DEPTH;
                end
                m_cmd = -1;
                m_args.delete();
            end
        end
    endtask

    // One clock cycle: drive, check on the falling edge, then advance the model.
    task automatic step(input logic v, input logic [7:0] d, input logic rr,
                        input logic rst, output logic acc);
        bit          exp_busy, exp_ready, exp_rbv;
        logic [7:0]  exp_rbd;
        int          a;
        ld_valid  = v;
        ld_data   = d;
        rb_ready  = rr;
        RST       = rst;
        prog_addr = pa;
        exp_busy  = (m_cmd >= 0);
        exp_ready = (m_cmd != 'hA2);
        exp_rbv   = (m_cmd == 'hA2);
        @(negedge CLK);
        chk("busy", 16'(busy), 16'(exp_busy));
        chk("ld_ready", 16'(ld_ready), 16'(exp_ready));
        chk("rb_valid", 16'(rb_valid), 16'(exp_rbv));
        if (!exp_rbv) begin
            chk("rb_data_idle", 16'(rb_data), 16'h0000);
        end else if (m_known[m_addr]) begin
            exp_rbd = (m_rb_idx == 0) ? m_mem[m_addr][7:0] : m_mem[m_addr][15:8];
            chk("rb_data", 16'(rb_data), 16'(exp_rbd));
        end
        a = int'(pa) % DEPTH;
        if (exp_busy) begin
            chk("prog_data_busy", prog_data, 16'h0000);
        end else if (m_known[a]) begin
            chk("prog_data", prog_data, m_mem[a]);
        end
        acc = !rst && v && exp_ready;
        @(posedge CLK);
        if (rst) begin
            model_reset();
        end else if (m_cmd == 'hA2) begin
            if (rr) begin
                m_rb_idx++;
                if (m_rb_idx == 2) begin
                    m_rb_idx = 0;
                    m_addr = (m_addr + 1) % DEPTH;
                    m_cmd = -1;
                end
            end
        end else if (acc) begin
            model_byte(d);
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'($urandom), 1'b0, acc);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        logic acc;
        int   tries;
        idle($urandom_range(0, max_gap));
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            step(1'b1, b, 1'($urandom), 1'b0, acc);
            tries++;
        end
        if (!acc) chk("accept_timeout", 16'h0000, 16'h0001);
    endtask

    task automatic pulse_reset();
        logic acc;
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        @(posedge CLK);
        #1;
        pulse_reset();
        pa = 16'h0005;
        idle(2);

        // Preload mem[5], then prove reset leaves it intact.
        send_byte(8'hA0, 0); send_byte(8'h05, 0); send_byte(8'h00, 0);
        send_byte(8'hA1, 0); send_byte(8'h5A, 0); send_byte(8'hC3, 0);
        pulse_reset();
        idle(1);
        chk("preload_mem5", prog_data, 16'hC35A);

        // SETA 0x0010, WR 0x1234, then an address-less write lands at 0x011.
        pa = 16'h0010;
        send_byte(8'hA0, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        send_byte(8'hA1, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
        idle(1);
        chk("mem_010", prog_data, 16'h1234);
        pa = 16'h0011;
        send_byte(8'hA1, 0); send_byte(8'h77, 0); send_byte(8'h66, 0);
        idle(1);
        chk("mem_011", prog_data, 16'h6677);

        // Wrap from the last word back to zero.
        send_byte(8'hA0, 0); send_byte(8'hFF, 0); send_byte(8'h01, 0);
        send_byte(8'hA1, 0); send_byte(8'hEF, 0); send_byte(8'hBE, 0);
        send_byte(8'hA1, 0); send_byte(8'hFE, 0); send_byte(8'hCA, 0);
        pa = 16'h01FF; idle(1);
        chk("mem_1ff", prog_data, 16'hBEEF);
        pa = 16'h0000; idle(1);
        chk("mem_000_wrap", prog_data, 16'hCAFE);

        // Reset mid-write discards the partial word; address returns to 0.
        send_byte(8'hA1, 0); send_byte(8'hAA, 0);
        pulse_reset();
        idle(1);
        chk("mem_000_no_write", prog_data, 16'hCAFE);
        send_byte(8'hA1, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        idle(1);
        chk("mem_000_after_rst", prog_data, 16'h0001);

        // Unknown byte dropped, gaps mid-command, upper fetch bits ignored.
        send_byte(8'h3C, 0);
        send_byte(8'hA0, 3); send_byte(8'h20, 3); send_byte(8'h00, 3);
        send_byte(8'hA1, 3); send_byte(8'h22, 4); send_byte(8'h11, 4);
        pa = 16'h0220; idle(1);
        chk("mem_020_gaps", prog_data, 16'h1122);
        pa = 16'h0210; idle(1);
        chk("alias_0210", prog_data, 16'h1234);

`ifdef PMEM_READBACK_EN
        send_byte(8'hA0, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        send_byte(8'hA2, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hA1, 1'b0, 1'b0, acc);
        chk("rb_lo_held", 16'(rb_data), 16'h0034);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        chk("rb_hi", 16'(rb_data), 16'h0012);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        pa = 16'h0011; idle(1);
        send_byte(8'hA1, 0); send_byte(8'h99, 0); send_byte(8'h88, 0);
        idle(1);
        chk("rb_addr_inc", prog_data, 16'h8899);
`else
        send_byte(8'hA2, 0);
        idle(1);
        chk("rd_dropped_busy", 16'(busy), 16'h0000);
`endif

        // Random traffic over a small address window so fetch hits written words.
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            pa = {7'($urandom), 4'h0, 5'($urandom)};
            if (kind < 3) begin
                send_byte(8'hA0, 2);
                send_byte(8'($urandom_range(0, 31)), 2);
                send_byte(8'($urandom), 2);
            end else if (kind < 7) begin
                send_byte(8'hA1, 2);
                send_byte(8'($urandom), 2);
                send_byte(8'($urandom), 2);
            end else if (kind == 7) begin
                send_byte(8'hA2, 2);
            end else if (kind == 8) begin
                send_byte(8'($urandom), 2);
            end else begin
                send_byte(8'hA1, 1);
                send_byte(8'($urandom), 1);
                pulse_reset();
            end
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/avr_pmem_ctrl.md
Name: avr_pmem_ctrl

Overview:
Program-memory responder for the avr_fetch unit. It serves `prog_addr` to `prog_data` on the fetch side and owns a byte-wide programming (loader) port. The loader parses a small command stream, assembles 16-bit little-endian words and writes them into the word array. `busy` stalls the core while a loader command is in flight.

Parameters:
- ADDR_W, 9, word-address width; DEPTH = 2**ADDR_W words (512).
- NOP_WORD, 16'h0000, value driven on `prog_data` while `busy`.
- CMD_SETA, 8'hA0, set-address command byte.
- CMD_WR, 8'hA1, write-word command byte.
- CMD_RD, 8'hA2, read-back command byte (optional feature only).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- prog_addr  in  16  word address from fetch; bits [ADDR_W-1:0] are used, upper bits ignored.
- prog_data  out  16  instruction word to fetch.
- busy  out  1  loader mid-command; core must hold the PC.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_ready  out  1  loader byte accepted when `ld_valid && ld_ready`.
- rb_valid  out  1  read-back byte valid.
- rb_data  out  8  read-back byte.
- rb_ready  in  1  read-back sink ready.

Behaviour:
- Reset (RST=1 at an edge):
  - state=IDLE, ld_addr=0, word latch=0, busy=0, ld_ready=1, rb_valid=0, rb_data=0.
  - Memory contents are not cleared.
- Fetch read is combinational, zero latency: `prog_data = busy ? NOP_WORD : mem[prog_addr[ADDR_W-1:0]]`.
- A byte is consumed only on an edge where `ld_valid && ld_ready`. `ld_ready` = 1 in every state except RB_LO/RB_HI.
- FSM states: IDLE, A_LO, A_HI, W_LO, W_HI, RB_LO, RB_HI.
- IDLE transitions:
  - CMD_SETA -> A_LO.
  - CMD_WR -> W_LO.
  - CMD_RD -> RB_LO (optional feature only).
  - Any other byte is dropped; stay in IDLE.
- A_LO: latch low address byte -> A_HI.
- A_HI: `ld_addr <= {hi,lo}[ADDR_W-1:0]` -> IDLE.
- W_LO: latch low data byte -> W_HI.
- W_HI: in the same edge, `mem[ld_addr] <= {byte,lo}` and `ld_addr <= ld_addr+1` (wraps DEPTH-1 -> 0) -> IDLE.
- `busy` = (state != IDLE), registered with the state. It asserts the cycle after the command byte is accepted and deasserts the cycle after the final byte.
- Write/read collision: a write to the word currently addressed by fetch is visible on `prog_data` from the cycle after the write edge. `busy` masks it the cycle before.
- No timeout: an idle loader mid-command leaves busy=1 indefinitely. RST is the only abort. RST mid-command discards the partial word with no memory write; the address returns to 0.
- `ld_valid` low: no state change in any state.

Optional Feature:
- Macro: PMEM_READBACK_EN.
- Defined:
  - CMD_RD in IDLE -> RB_LO, with `rb_data = mem[ld_addr][7:0]` and `rb_valid=1`.
  - On `rb_ready` -> RB_HI, with `rb_data = [15:8]`.
  - On `rb_ready` -> IDLE, with `rb_valid=0` and `ld_addr+1`.
  - busy=1 throughout.
- Undefined:
  - CMD_RD is treated as an unknown byte (dropped).
  - rb_valid=0 and rb_data=0 are constant; rb_ready is ignored.
  - The ports remain present.

Decomposition:
- Package avr_pmem_pkg holds:
  - the FSM state encoding (3-bit);
  - CMD_SETA/CMD_WR/CMD_RD constants;
  - NOP_WORD.
- One natural sub-module: avr_pmem_array (DEPTH×16 array, combinational read, single synchronous write port).
- The loader FSM stays in avr_pmem_ctrl.

Test Plan:
1. RST=1 one edge, then idle -> busy=0, ld_ready=1, rb_valid=0; prog_addr=0x0005 returns the preloaded mem[5].
2. Bytes A0,10,00,A1,34,12 -> mem[0x010]=0x1234, ld_addr=0x011. busy=1 from the cycle after A0 until the cycle after 0x12. prog_data=0x0000 while busy.
3. SETA 0x01FF, then WR 0xBEEF, WR 0xCAFE -> mem[0x1FF]=0xBEEF, mem[0x000]=0xCAFE (wrap).
4. Bytes A1,AA, then RST=1 -> no write to mem[0]; state IDLE, busy=0. Subsequent A1,01,00 writes 0x0001 to mem[0].
5. Unknown byte 0x3C in IDLE, and ld_valid=0 gaps mid-command -> the 0x3C is dropped with no state change. Gaps stall without corrupting the latched byte. prog_addr=0x0210 with ADDR_W=9 reads mem[0x010].
6. (PMEM_READBACK_EN) SETA 0x0010, RD, rb_ready held low 3 cycles, then high -> rb_data 0x34 held stable, then 0x12. ld_ready=0 during read-back; ld_addr=0x011 afterwards.
